// File: rtl/out_bus_mem_responder.sv
// +--------------------------------------------------------------------------+
// | out_bus_mem_responder: burst write/read responder for the output bus.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module out_bus_mem_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int BURST_WIDTH = 4
) (
  input  logic                   w_clock,
  input  logic                   w_reset,
  input  logic                   w_start,
  input  logic [BURST_WIDTH-1:0] w_burst,
  input  logic                   w_rw,
  input  logic [ADDR_WIDTH-1:0]  w_addr,
  input  logic                   w_beat_valid,
  input  logic [DATA_WIDTH-1:0]  w_wdata,
  output logic [DATA_WIDTH-1:0]  r_rdata,
  output logic                   r_rvalid,
  output logic                   r_busy,
  output logic                   r_done,
  output logic                   r_err
);

  localparam int C_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [BURST_WIDTH-1:0] r_last;
  logic [BURST_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_mem [C_DEPTH];

  logic [ADDR_WIDTH-1:0]  w_beat_addr;
  logic                   w_in_burst;
  logic                   w_wr_en;

  // Address arithmetic wraps naturally at the buffer boundary.
  assign w_beat_addr = r_base + ADDR_WIDTH'(r_cnt);
  assign w_in_burst  = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign w_wr_en     = w_beat_valid && (r_state == ST_WRITE);

  // Buffer contents survive reset.
  always_ff @(posedge w_clock) begin
    if (w_wr_en) begin
      r_mem[w_beat_addr] <= w_wdata;
    end
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;

      if (w_start && (r_state != ST_IDLE)) begin
        r_err <= 1'b1;
      end
      if (w_beat_valid && !w_in_burst) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_base  <= w_addr;
            r_last  <= w_burst;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= w_rw ? ST_READ : ST_WRITE;
          end
        end
        ST_WRITE, ST_READ: begin
          if (w_beat_valid) begin
            if (r_state == ST_READ) begin
              r_rdata  <= r_mem[w_beat_addr];
              r_rvalid <= 1'b1;
            end
            // Leaving on the last index keeps the beat counter from wrapping.
            if (r_cnt == r_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_out_bus_mem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_out_bus_mem_responder: directed scoreboard bench for the responder.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_out_bus_mem_responder;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int BW = 4;

  logic          w_clock;
  logic          w_reset;
  logic          w_start;
  logic [BW-1:0] w_burst;
  logic          w_rw;
  logic [AW-1:0] w_addr;
  logic          w_beat_valid;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] sb [$];
  logic          exp_rv = 1'b0;
  logic [DW-1:0] mdl [256];

  out_bus_mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_WIDTH(BW)
  ) dut (
    .w_clock     (w_clock),
    .w_reset     (w_reset),
    .w_start     (w_start),
    .w_burst     (w_burst),
    .w_rw        (w_rw),
    .w_addr      (w_addr),
    .w_beat_valid(w_beat_valid),
    .w_wdata     (w_wdata),
    .r_rdata     (r_rdata),
    .r_rvalid    (r_rvalid),
    .r_busy      (r_busy),
    .r_done      (r_done),
    .r_err       (r_err)
  );

  initial begin
    w_clock = 1'b0;
    forever #5 w_clock = ~w_clock;
  end

  task automatic ckb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic ckd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ckn(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; read data is matched against the scoreboard whenever it appears.
  task automatic cycle();
    logic [DW-1:0] e;
    @(posedge w_clock);
    #1;
    ckb("rvalid", r_rvalid, exp_rv);
    if (r_rvalid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=rvalid expected=no_rvalid");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        ckd("rdata", r_rdata, e);
      end
    end
    exp_rv = 1'b0;
  endtask

  task automatic start(input logic rw, input logic [BW-1:0] burst, input logic [AW-1:0] addr);
    w_start = 1'b1;
    w_rw    = rw;
    w_burst = burst;
    w_addr  = addr;
    cycle();
    w_start = 1'b0;
    ckb("busy_after_start", r_busy, 1'b1);
    ckb("done_after_start", r_done, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    w_beat_valid = 1'b1;
    w_wdata      = data;
    mdl[addr]    = data;
    cycle();
    w_beat_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    w_beat_valid = 1'b1;
    sb.push_back(mdl[addr]);
    exp_rv = 1'b1;
    cycle();
    w_beat_valid = 1'b0;
  endtask

  task automatic readback(input logic [AW-1:0] base, input int burst);
    start(1'b1, BW'(burst), base);
    for (int i = 0; i <= burst; i++) begin
      rd(base + AW'(i));
      ckb("rd_done", r_done, i == burst);
    end
    cycle();
    ckn("rd_drain", sb.size(), 0);
    ckb("rd_idle_done", r_done, 1'b0);
    ckb("rd_idle_busy", r_busy, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    ckd({tag, "_rdata"}, r_rdata, '0);
    ckb({tag, "_rvalid"}, r_rvalid, 1'b0);
    ckb({tag, "_busy"}, r_busy, 1'b0);
    ckb({tag, "_done"}, r_done, 1'b0);
    ckb({tag, "_err"}, r_err, 1'b0);
  endtask

  task automatic do_reset();
    w_reset = 1'b1;
    #1;
    check_cleared("rst");
    ckn("sb_empty_at_reset", sb.size(), 0);
    sb.delete();
    exp_rv = 1'b0;
    @(posedge w_clock);
    #1;
    w_reset = 1'b0;
  endtask

  initial begin
    w_reset      = 1'b0;
    w_start      = 1'b0;
    w_rw         = 1'b0;
    w_burst      = '0;
    w_addr       = '0;
    w_beat_valid = 1'b0;
    w_wdata      = '0;
    #1;
    w_reset = 1'b1;
    #1;
    check_cleared("por");
    @(posedge w_clock);
    #1;
    w_reset = 1'b0;

    // T1: four-beat write at 0x10
    start(1'b0, 4'd3, 8'h10);
    for (int i = 0; i < 4; i++) begin
      wr(8'h10 + AW'(i), 8'hA0 + DW'(i));
      ckb("t1_done", r_done, i == 3);
      ckb("t1_busy", r_busy, 1'b1);
    end
    cycle();
    ckb("t1_idle_done", r_done, 1'b0);
    ckb("t1_idle_busy", r_busy, 1'b0);
    ckb("t1_err", r_err, 1'b0);

    // T2: read back, rdata holds after the burst
    readback(8'h10, 3);
    ckd("t2_hold", r_rdata, 8'hA3);

    // T3: wrap past 0xFF with stalls
    start(1'b0, 4'd2, 8'hFF);
    wr(8'hFF, 8'hB0);
    cycle();
    cycle();
    ckb("t3_gap_busy", r_busy, 1'b1);
    ckb("t3_gap_done", r_done, 1'b0);
    wr(8'h00, 8'hB1);
    ckb("t3_done_early", r_done, 1'b0);
    wr(8'h01, 8'hB2);
    ckb("t3_done", r_done, 1'b1);
    cycle();
    readback(8'hFF, 2);
    ckb("t3_err", r_err, 1'b0);

    // T4: single beat, then maximum burst plus a stray beat in DONE
    start(1'b0, 4'd0, 8'h40);
    wr(8'h40, 8'hC0);
    ckb("t4_single_done", r_done, 1'b1);
    cycle();
    ckb("t4_single_idle", r_busy, 1'b0);
    start(1'b0, 4'hF, 8'h80);
    for (int i = 0; i < 16; i++) begin
      wr(8'h80 + AW'(i), 8'h30 + DW'(i));
      ckb("t4_max_done", r_done, i == 15);
    end
    ckb("t4_err_before", r_err, 1'b0);
    w_beat_valid = 1'b1;
    w_wdata      = 8'hEE;
    cycle();
    w_beat_valid = 1'b0;
    ckb("t4_err_after", r_err, 1'b1);
    ckb("t4_busy_after", r_busy, 1'b0);
    readback(8'h80, 15);
    readback(8'h40, 0);

    // T5: start during a write burst is ignored but flagged
    do_reset();
    ckb("t5_err_clear", r_err, 1'b0);
    start(1'b0, 4'd3, 8'h20);
    wr(8'h20, 8'hD0);
    w_start = 1'b1;
    w_rw    = 1'b1;
    w_addr  = 8'h50;
    w_burst = 4'd0;
    wr(8'h21, 8'hD1);
    w_start = 1'b0;
    ckb("t5_err", r_err, 1'b1);
    ckb("t5_busy", r_busy, 1'b1);
    ckb("t5_no_done", r_done, 1'b0);
    wr(8'h22, 8'hD2);
    wr(8'h23, 8'hD3);
    ckb("t5_done", r_done, 1'b1);
    cycle();
    ckb("t5_err_sticky", r_err, 1'b1);
    readback(8'h20, 3);

    // T6: asynchronous reset in the middle of a read burst
    do_reset();
    start(1'b1, 4'd3, 8'h10);
    rd(8'h10);
    rd(8'h11);
    w_beat_valid = 1'b1;
    #3;
    w_reset = 1'b1;
    #1;
    check_cleared("t6_abort");
    w_beat_valid = 1'b0;
    @(posedge w_clock);
    #1;
    w_reset = 1'b0;
    cycle();
    ckb("t6_no_done", r_done, 1'b0);
    readback(8'h10, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
